// File: rtl/pipe_pkg.sv
// Shared types and constants for the core pipeline stage registers.
package pipe_pkg;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } id_ex_t;

  localparam int          PIPE_DATA_W = $bits(if_id_t);
  localparam logic [63:0] NOP_PAYLOAD = {32'h0, RV32_NOP};

  typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_e;

  function automatic if_id_t mk_if_id(input logic [31:0] pc, input logic [31:0] instr);
    if_id_t r;
    r.pc    = pc;
    r.instr = instr;
    return r;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running wrap-around event counter with enable.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with 2-entry skid buffer, stall and bubble-inserting flush.
// PIPE_STAGE_PERF_EN adds stall/flush/bubble performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W    = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_PAYLOAD)
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int              CNT_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,        // active-high despite the name
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

  pipe_state_e       state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              rdy_q;
  logic              dr, in_xfer, out_xfer;

  assign dr          = out_ready_i & ~stall_i;
  assign out_valid_o = (state != EMPTY);
  assign out_data_o  = main_q;
  assign in_ready_o  = rdy_q;
  assign in_xfer     = in_valid_i & rdy_q & ~flush_i;
  assign out_xfer    = out_valid_o & dr & ~flush_i;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush_i) begin
      state_nxt = EMPTY;
      main_nxt  = NOP_VALUE;
      skid_nxt  = NOP_VALUE;
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          state_nxt = ONE;
          main_nxt  = in_data_i;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_nxt = in_data_i;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
            main_nxt  = NOP_VALUE;
          end else if (in_xfer) begin
            state_nxt = FULL;
            skid_nxt  = in_data_i;
          end
        end
        FULL: if (out_xfer) begin
          state_nxt = ONE;
          main_nxt  = skid_q;
          skid_nxt  = NOP_VALUE;
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = NOP_VALUE;
          skid_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  // Ready is taken from the next skid occupancy so it never sees out_ready_i combinationally.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
      rdy_q  <= 1'b1;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
      rdy_q  <= (state_nxt != FULL);
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst_n), .en(out_valid_o & ~dr & ~flush_i), .cnt(stall_cnt_o)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst_n), .en(flush_i & (state != EMPTY)), .cnt(flush_cnt_o)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst_n), .en(~out_valid_o), .cnt(bubble_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus pushes accepted words, monitor pops on output transfers.
module tb_pipe_stage_reg;

  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]  stall_cnt, flush_cnt, bubble_cnt;
`endif

  int          checks = 0;
  int          failures = 0;
  int          n_out = 0;
  logic [63:0] sb[$];

  bit bp_ordy [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
  bit bp_rdy  [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
  bit st_pat  [8] = '{0, 0, 0, 1, 1, 0, 0, 0};

  pipe_stage_reg #(
    .DATA_W(64)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .stall_i(stall), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .bubble_cnt_o(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] w(input logic [7:0] b);
    return 64'h1000_0000_0000_0000 | {56'h0, b};
  endfunction

  // Called at posedge+1: drive this cycle's inputs.
  task automatic set(input logic v, input logic [63:0] d, input logic ordy, input logic st, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  // Just before the edge, record whether the input side transfers, then step to posedge+1.
  task automatic adv(output bit acc);
    #8;
    acc = !rst && in_valid && in_ready && !flush;
    if (acc) sb.push_back(in_data);
    if (flush || rst) sb.delete();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid) chk("idle_nop", out_data, NOP);
      else if (out_ready && !stall && !flush) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %h expected none", out_data);
        end else chk("sb_data", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    bit acc;
    int idx;
    @(posedge clk); #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, NOP);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming: one word per cycle, one cycle latency.
    for (int c = 0; c < 9; c++) begin
      set(c < 8, w(8'hA0 + 8'(c)), 1, 0, 0);
      chk("stream_rdy", in_ready, 1);
      if (c > 0) begin
        chk("stream_vld", out_valid, 1);
        chk("stream_data", out_data, w(8'hA0 + 8'(c - 1)));
      end
      adv(acc);
    end
    set(0, '0, 1, 0, 0);
    chk("stream_empty", out_valid, 0);
    adv(acc);

    // Backpressure: skid takes one word, then ready drops.
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      set(idx < 4, w(8'hB0 + 8'(idx)), bp_ordy[c], 0, 0);
      chk("bp_rdy", in_ready, 64'(bp_rdy[c]));
      adv(acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 64'(idx), 4);
    set(0, '0, 1, 0, 0); adv(acc);

    // Stall: output held, then resumes in order.
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      set(idx < 6, w(8'hC0 + 8'(idx)), 1, st_pat[c], 0);
      if (c >= 3 && c <= 5) begin
        chk("stall_vld", out_valid, 1);
        chk("stall_hold", out_data, w(8'hC2));
      end
      if (c == 6) chk("stall_resume", out_data, w(8'hC3));
      adv(acc);
      if (acc) idx++;
    end
    chk("stall_accepted", 64'(idx), 6);
    for (int c = 0; c < 3; c++) begin
      set(0, '0, 1, 0, 0); adv(acc);
    end

    // Flush in FULL with a valid input and stall on the same cycle.
    set(1, w(8'hD0), 0, 0, 0); adv(acc);
    set(1, w(8'hD1), 0, 0, 0); adv(acc);
    set(1, w(8'hD2), 1, 1, 1);
    chk("full_rdy", in_ready, 0);
    adv(acc);
    set(0, '0, 1, 0, 0);
    chk("flush_vld", out_valid, 0);
    chk("flush_data", out_data, NOP);
    chk("flush_rdy", in_ready, 1);
    adv(acc);
    chk("flush_drop", out_valid, 0);
    adv(acc);

    // Asynchronous reset while FULL.
    set(1, w(8'hE0), 0, 0, 0); adv(acc);
    set(1, w(8'hE1), 0, 0, 0); adv(acc);
    set(0, '0, 0, 0, 0);
    chk("prerst_rdy", in_ready, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, NOP);
    chk("arst_rdy", in_ready, 1);
    #4 sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    set(1, w(8'hE2), 1, 0, 0); adv(acc);
    set(0, '0, 1, 0, 0);
    chk("post_rst_vld", out_valid, 1);
    chk("post_rst_data", out_data, w(8'hE2));
    adv(acc);
    set(0, '0, 1, 0, 0); adv(acc);

`ifdef PIPE_STAGE_PERF_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set(1, w(8'hF0), 1, 1, 0); adv(acc);
    for (int c = 0; c < 17; c++) begin
      set(0, '0, 1, 1, 0); adv(acc);
    end
    set(0, '0, 1, 1, 1); adv(acc);
    set(0, '0, 1, 0, 0);
    chk("perf_stall_wrap", 64'(stall_cnt), 1);
    chk("perf_flush", 64'(flush_cnt), 1);
    chk("perf_bubble", 64'(bubble_cnt), 1);
    adv(acc);
`endif

    chk("sb_drained", 64'(sb.size()), 0);
    chk("out_count", 64'(n_out), 19);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; successor to the fixed 32-bit IF/ID latch.
- Carries an arbitrary payload (PC, instruction, control bundle) with a valid/ready handshake.
- Uses a 2-entry skid buffer, so `in_ready_o` is registered.
- Supports a stall input and a synchronous flush that inserts a bubble (NOP payload). Instantiated between every pair of core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 64, payload width in bits (e.g. 32-bit PC + 32-bit instruction).
- NOP_VALUE, 64'h0000_0000_0000_0013, payload driven while the stage holds a bubble. Low 32 bits = RV32I `addi x0,x0,0`.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous, active-high reset. Asserted when 1; the name is kept per codebase port naming.
- in_valid_i, input, 1, upstream payload valid.
- in_ready_o, output, 1, stage can accept a payload (registered).
- in_data_i, input, DATA_W, upstream payload.
- stall_i, input, 1, hazard stall; freezes the output side.
- flush_i, input, 1, synchronous kill of all held entries.
- out_valid_o, output, 1, output payload valid.
- out_ready_i, input, 1, downstream accepts.
- out_data_o, output, DATA_W, output payload; NOP_VALUE when out_valid_o=0.

Behaviour:
- Reset (async, rst_n=1):
  - out_valid_o=0, out_data_o=NOP_VALUE, in_ready_o=1.
  - Skid entry invalid, skid data = NOP_VALUE, counters=0.
  - Reset asserted mid-transfer discards everything immediately; no handshake completes in that cycle.
- Handshake terms:
  - Effective downstream ready: `dr = out_ready_i & ~stall_i`.
  - Input transfer occurs when `in_valid_i & in_ready_o & ~flush_i`.
  - Output transfer occurs when `out_valid_o & dr & ~flush_i`.
- States, tracking main-register valid (M) and skid valid (S):
  - EMPTY (M=0, S=0):
    - Input transfer → ONE; main loads in_data_i. Latency 1 cycle, input to output.
  - ONE (M=1, S=0):
    - Input and output transfer together → ONE; main loads new data.
    - Output transfer only → EMPTY; main data becomes NOP_VALUE.
    - Input transfer only → FULL; skid loads in_data_i.
    - Neither → hold.
  - FULL (M=1, S=1), in_ready_o=0:
    - Output transfer → ONE; main loads skid data, skid cleared to NOP_VALUE.
    - Otherwise → hold.
- in_ready_o next value = ~(next S). Never depends combinationally on out_ready_i.
- Flush has priority over stall and over both transfers:
  - Next state EMPTY; main and skid data = NOP_VALUE; in_ready_o=1 next cycle.
  - Any payload presented on the same cycle is dropped.
- Stall alone behaves exactly like out_ready_i=0. An input can still fill the skid entry while stalled.
- While out_valid_o=1 and no output transfer occurs, out_data_o must stay stable.
- Payload is passed bit-exact; no arithmetic on data.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds outputs
  - stall_cnt_o [CNT_W]: increments each cycle with out_valid_o=1 and dr=0 and flush_i=0.
  - flush_cnt_o [CNT_W]: increments each cycle flush_i=1 while M or S is set.
  - bubble_cnt_o [CNT_W]: increments each cycle out_valid_o=0.
  - All three wrap modulo 2^CNT_W and are cleared by reset.
- Not defined: ports and logic absent; datapath and handshake behaviour identical.

Decomposition:
- Package `pipe_pkg`:
  - RV32 NOP constant.
  - Default DATA_W.
  - Typedef `pipe_state_e {EMPTY, ONE, FULL}`.
  - Per-stage payload struct typedefs (`if_id_t`, `id_ex_t`) whose widths feed DATA_W.
- One natural sub-module: `pipe_perf_cnt`, a single wrap-around counter with enable, instantiated three times under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: assert rst_n=1 mid-cycle with FULL state → immediately out_valid_o=0, out_data_o=64'h13, in_ready_o=1.
- Streaming: in_valid_i=1 with data 0x1000_0000_0000_00A0..A7, out_ready_i=1 → each word appears 1 cycle later in order, one per cycle, no gaps.
- Backpressure: out_ready_i=0 for 3 cycles during a stream → skid captures exactly one word, then in_ready_o=0. On release the words appear with no loss or duplication.
- Stall: stall_i=1 for 2 cycles with out_ready_i=1 → out_data_o held (e.g. 0x...A2) and out_valid_o held at 1. Resumes with 0x...A3.
- Flush in FULL state, with in_valid_i=1 and stall_i=1 on the same cycle → next cycle out_valid_o=0, out_data_o=NOP_VALUE, in_ready_o=1. Input word not accepted.
- PIPE_STAGE_PERF_EN with CNT_W=4 and 17 stall cycles → stall_cnt_o=1 (wrap); flush_cnt_o=1 after one flush.
